// File: rtl/movebit_inv.sv
// Iterative bit-move inverse: popcount of imm16, low-bit inversion of read1, then a
// serial left shift by that count. Define MOVEBIT_INV_FAST_COUNT_EN to skip the serial COUNT state.
module movebit_inv #(
    parameter int WIDTH = 32,
    parameter int IMM_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] read1,
    input  logic [IMM_W-1:0] imm16,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] moveout,
    output logic [1:0]       state_o
);
    localparam int CNT_W = $clog2(IMM_W + 1);
    localparam int IDX_W = $clog2(IMM_W);

    // Handshake: start is sampled only in IDLE; busy is high from the accepting edge
    // through the DONE cycle; done pulses one cycle, the same cycle moveout updates.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   moveout_q, moveout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;

    function automatic logic [WIDTH-1:0] pre_shift(input logic [WIDTH-1:0] d,
                                                   input logic [IMM_W-1:0] imm,
                                                   input logic [CNT_W-1:0] c);
        if (imm >= IMM_W'(32)) return ~d;
        return d ^ ~({WIDTH{1'b1}} << c);
    endfunction

`ifdef MOVEBIT_INV_FAST_COUNT_EN
    function automatic logic [CNT_W-1:0] popcount(input logic [IMM_W-1:0] imm);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < IMM_W; i++) c = c + CNT_W'(imm[i]);
        return c;
    endfunction

    logic [CNT_W-1:0] pc;
    assign pc = popcount(imm16);
`else
    logic [IMM_W-1:0] imm_q, imm_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_inc;
`endif

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        moveout_d = moveout_q;
        done_d    = 1'b0;
`ifndef MOVEBIT_INV_FAST_COUNT_EN
        imm_d     = imm_q;
        idx_d     = idx_q;
        cnt_inc   = cnt_q + CNT_W'(imm_q[idx_q]);
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef MOVEBIT_INV_FAST_COUNT_EN
                    cnt_d   = pc;
                    data_d  = pre_shift(read1, imm16, pc);
                    state_d = (pc != '0) ? S_SHIFT : S_DONE;
`else
                    data_d  = read1;
                    imm_d   = imm16;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_COUNT;
`endif
                end
            end
`ifndef MOVEBIT_INV_FAST_COUNT_EN
            S_COUNT: begin
                cnt_d = cnt_inc;
                idx_d = idx_q + 1'b1;
                // The final bit must be included before the transform, hence cnt_inc.
                if (idx_q == IDX_W'(IMM_W - 1)) begin
                    data_d  = pre_shift(data_q, imm_q, cnt_inc);
                    state_d = (cnt_inc != '0) ? S_SHIFT : S_DONE;
                end
            end
`endif
            S_SHIFT: begin
                data_d = data_q << 1;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                moveout_d = data_q;
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            moveout_q <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
`ifndef MOVEBIT_INV_FAST_COUNT_EN
            imm_q     <= '0;
            idx_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            moveout_q <= moveout_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
`ifndef MOVEBIT_INV_FAST_COUNT_EN
            imm_q     <= imm_d;
            idx_q     <= idx_d;
`endif
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign moveout = moveout_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_movebit_inv.sv
// Randomized bench for movebit_inv against a behavioural result/latency model;
// honours MOVEBIT_INV_FAST_COUNT_EN for the expected latency.
module tb_movebit_inv;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] read1 = '0;
    logic [15:0] imm16 = '0;
    logic        busy, done;
    logic [31:0] moveout;
    logic [1:0]  state_o;

    int n_chk = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

`ifdef MOVEBIT_INV_FAST_COUNT_EN
    localparam int BASE_LAT = 1;
    localparam int SHIFT_AT = 3;
`else
    localparam int BASE_LAT = 17;
    localparam int SHIFT_AT = 20;
`endif

    movebit_inv #(.WIDTH(32), .IMM_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .read1(read1), .imm16(imm16),
        .busy(busy), .done(done), .moveout(moveout), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: invert (all bits if imm>=32, else the low popcount bits), then shift.
    function automatic logic [31:0] ref_move(input logic [31:0] d, input logic [15:0] imm);
        int c;
        logic [31:0] r;
        c = $countones(imm);
        if (imm >= 16'd32) r = ~d;
        else r = d ^ ((32'd1 << c) - 32'd1);
        return r << c;
    endfunction

    // Called just after a rising edge; returns just after the edge that raises done.
    task automatic run_op(input string tag, input logic [31:0] rd, input logic [15:0] im,
                          input bit junk_mid, input bit junk_done);
        int lat, k;
        lat = BASE_LAT + $countones(im);
        exp_q.push_back(ref_move(rd, im));
        start = 1'b1; read1 = rd; imm16 = im;
        @(posedge clk); #1;
        start = 1'b0; read1 = $urandom; imm16 = 16'($urandom);
        chk({tag, "_busy_acc"}, 32'(busy), 32'd1);
        chk({tag, "_done_low"}, 32'(done), 32'd0);
        k = 0;
        while (k < 100) begin
            @(posedge clk); #1;
            k++;
            start = 1'b0;
            if (done) break;
            if (!busy) chk({tag, "_busy_hold"}, 32'(busy), 32'd1);
            if (junk_mid && k == 5 && lat > 7) begin
                start = 1'b1; read1 = $urandom; imm16 = 16'($urandom);
            end
            if (junk_done && k == lat - 1 && lat > 2) begin
                start = 1'b1; read1 = $urandom; imm16 = 16'($urandom);
            end
        end
        chk({tag, "_latency"}, 32'(k), 32'(lat));
        chk({tag, "_moveout"}, moveout, exp_q.pop_front());
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        bit seen;
        // Reset held low with random inputs
        for (int i = 0; i < 5; i++) begin
            start = 1'($urandom); read1 = $urandom; imm16 = 16'($urandom);
            @(posedge clk); #1;
        end
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_moveout", moveout, 32'd0);
        chk("rst_state", 32'(state_o), 32'd0);
        start = 1'b0;
        #3 reset = 1'b1;
        @(posedge clk); #1;

        run_op("zero_imm", 32'h1234_5678, 16'h0000, 1'b0, 1'b0);
        run_op("imm3", 32'h0000_0001, 16'h0003, 1'b0, 1'b0);
        run_op("imm_ff", 32'h0000_00FF, 16'h00FF, 1'b0, 1'b1);
        run_op("imm_ffff", 32'h0000_1234, 16'hFFFF, 1'b1, 1'b0);

        // Abort during SHIFT: reset clears outputs asynchronously, operation is lost
        start = 1'b1; read1 = 32'h0000_1234; imm16 = 16'hFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (SHIFT_AT) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("abort_moveout", moveout, 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_state", 32'(state_o), 32'd0);
        #2 reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        chk("abort_lost", 32'(seen), 32'd0);

        for (int i = 0; i < 12; i++) begin
            logic [15:0] im;
            im = (i % 3 == 0) ? 16'($urandom_range(0, 31)) : 16'($urandom_range(0, 65535));
            run_op($sformatf("rnd%0d", i), $urandom, im, (i % 2) == 1, (i % 4) == 2);
        end

        @(posedge clk); #1;
        chk("final_done_pulse", 32'(done), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
